// File: rtl/timing_seq_if.sv
// Timing-sequencer bus: synchronisation inputs and timing words from the PPI
// frame receiver, plus the per-period gates and status returned by the sequencer.
// Signalling on this bus:
//   - There is no valid/ready pair.
//   - fs1 is a pulse and run is a level.
//   - The timing words are only meaningful while run is high.
//   - All outputs are registered, level or one-cycle pulse.
interface timing_seq_if #(
    parameter int CW = 32
);
    logic          fs1;
    logic          run;
    logic [CW-1:0] TNO;
    logic [CW-1:0] TNC;
    logic [CW-1:0] TOBM;
    logic [CW-1:0] TNI;
    logic [CW-1:0] TKI;
    logic [CW-1:0] TNP;
    logic [CW-1:0] TKP;
    logic          tx_gate;
    logic          rx_gate;
    logic          prd_strobe;
    logic [CW-1:0] prd_num;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output fs1, run, TNO, TNC, TOBM, TNI, TKI, TNP, TKP,
        input  tx_gate, rx_gate, prd_strobe, prd_num, busy, done, err
    );

    modport slave (
        input  fs1, run, TNO, TNC, TOBM, TNI, TKI, TNP, TKP,
        output tx_gate, rx_gate, prd_strobe, prd_num, busy, done, err
    );
endinterface

// File: rtl/timing_seq.sv
// Period sequencer: shadows the timing words on each new valid frame, and on each
// fs1 runs a start delay followed by TNC periods of TOBM ticks.
// During each period it drives the tx/rx gate windows.
module timing_seq #(
    parameter int CW          = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    timing_seq_if.slave bus,
    output logic [1:0] state_dbg
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [SYNC_STAGES-1:0] fs1_sync;
    logic [SYNC_STAGES-1:0] run_sync;
    logic                   fs1_d;
    logic                   run_d;
    logic                   fs1_rise;
    logic                   run_rise;

    logic                   sh_valid;
    logic [CW-1:0]          sh_tno, sh_tnc, sh_tobm, sh_tni, sh_tki, sh_tnp, sh_tkp;
    logic [CW-1:0]          a_tno, a_tnc, a_tobm, a_tni, a_tki, a_tnp, a_tkp;

    logic [1:0]             state;
    logic [CW-1:0]          dcnt;
    logic [CW-1:0]          pcnt;
    logic [CW-1:0]          pnum;

    logic                   tx_q, rx_q, strobe_q, busy_q, done_q, err_q;
    logic [CW-1:0]          num_q;

    // Bring fs1/run into the clk domain and keep the last synced value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs1_sync <= '0;
            run_sync <= '0;
            fs1_d    <= 1'b0;
            run_d    <= 1'b0;
        end else begin
            fs1_sync <= {fs1_sync[SYNC_STAGES-2:0], bus.fs1};
            run_sync <= {run_sync[SYNC_STAGES-2:0], bus.run};
            fs1_d    <= fs1_sync[SYNC_STAGES-1];
            run_d    <= run_sync[SYNC_STAGES-1];
        end
    end

    assign fs1_rise = fs1_sync[SYNC_STAGES-1] & ~fs1_d;
    assign run_rise = run_sync[SYNC_STAGES-1] & ~run_d;

    // Capture the timing words once per valid frame; a start in the same cycle still sees the old set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_valid <= 1'b0;
            sh_tno   <= '0;
            sh_tnc   <= '0;
            sh_tobm  <= '0;
            sh_tni   <= '0;
            sh_tki   <= '0;
            sh_tnp   <= '0;
            sh_tkp   <= '0;
        end else if (run_rise) begin
            sh_valid <= 1'b1;
            sh_tno   <= bus.TNO;
            sh_tnc   <= bus.TNC;
            sh_tobm  <= bus.TOBM;
            sh_tni   <= bus.TNI;
            sh_tki   <= bus.TKI;
            sh_tnp   <= bus.TNP;
            sh_tkp   <= bus.TKP;
        end
    end

    // Sequencer: a start (accepted or rejected) overrides whatever the FSM was doing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            dcnt   <= '0;
            pcnt   <= '0;
            pnum   <= '0;
            a_tno  <= '0;
            a_tnc  <= '0;
            a_tobm <= '0;
            a_tni  <= '0;
            a_tki  <= '0;
            a_tnp  <= '0;
            a_tkp  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (fs1_rise) begin
                if (!sh_valid || sh_tobm == '0 || sh_tnc == '0) begin
                    state <= ST_IDLE;
                    err_q <= 1'b1;
                end else begin
                    a_tno  <= sh_tno;
                    a_tnc  <= sh_tnc;
                    a_tobm <= sh_tobm;
                    a_tni  <= sh_tni;
                    a_tki  <= sh_tki;
                    a_tnp  <= sh_tnp;
                    a_tkp  <= sh_tkp;
                    dcnt   <= '0;
                    state  <= ST_DELAY;
                end
            end else begin
                case (state)
                    ST_DELAY: begin
                        if (dcnt == a_tno) begin
                            state <= ST_RUN;
                            pcnt  <= '0;
                            pnum  <= '0;
                        end else begin
                            dcnt <= dcnt + CW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (pcnt == a_tobm - CW'(1)) begin
                            pcnt <= '0;
                            if (pnum == a_tnc - CW'(1)) begin
                                state  <= ST_IDLE;
                                done_q <= 1'b1;
                            end else begin
                                pnum <= pnum + CW'(1);
                            end
                        end else begin
                            pcnt <= pcnt + CW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Register the gates and status from the current state/counters (one-cycle lag by design)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
            tx_q     <= 1'b0;
            rx_q     <= 1'b0;
            num_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            strobe_q <= (state == ST_RUN) && (pcnt == '0);
            tx_q     <= (state == ST_RUN) && (pcnt >= a_tni) && (pcnt < a_tki);
            rx_q     <= (state == ST_RUN) && (pcnt >= a_tnp) && (pcnt < a_tkp);
            num_q    <= pnum;
            busy_q   <= (state != ST_IDLE);
        end
    end

    assign bus.prd_strobe = strobe_q;
    assign bus.tx_gate    = tx_q;
    assign bus.rx_gate    = rx_q;
    assign bus.prd_num    = num_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign state_dbg      = state;
endmodule

// File: tb/tb_timing_seq.sv
// Directed bench for timing_seq: expected output vectors are derived from the
// programmed timing words and queued, then popped and compared cycle by cycle.
module tb_timing_seq;
    localparam int CW = 32;
    localparam int W  = 14;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    timing_seq_if #(.CW(CW)) bus ();

    timing_seq #(.CW(CW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    int p_tno, p_tnc, p_tobm, p_tni, p_tki, p_tnp, p_tkp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // {err, done, busy, rx_gate, tx_gate, prd_strobe, prd_num[7:0]}
    function automatic logic [W-1:0] obs();
        return {bus.err, bus.done, bus.busy, bus.rx_gate, bus.tx_gate,
                bus.prd_strobe, bus.prd_num[7:0]};
    endfunction

    // Expected output after edge S+k, derived from the programmed timing words
    function automatic logic [W-1:0] exp_vec(input int k, input int prev_pn);
        int k0, last, j, pc, pn;
        logic st, tx, rx, bz, dn;
        k0   = p_tno + 2;
        last = k0 + p_tnc * p_tobm - 1;
        st = 1'b0; tx = 1'b0; rx = 1'b0;
        pn = prev_pn;
        bz = (k >= 1) && (k <= last);
        dn = (k == last);
        if (k >= k0 && k <= last) begin
            j  = k - k0;
            pc = j % p_tobm;
            pn = j / p_tobm;
            st = (pc == 0);
            tx = (pc >= p_tni) && (pc < p_tki);
            rx = (pc >= p_tnp) && (pc < p_tkp);
        end else if (k > last) begin
            pn = p_tnc - 1;
        end
        return {1'b0, dn, bz, rx, tx, st, 8'(pn)};
    endfunction

    // driver tasks
    task automatic set_words(input int tno, tnc, tobm, tni, tki, tnp, tkp);
        p_tno = tno; p_tnc = tnc; p_tobm = tobm;
        p_tni = tni; p_tki = tki; p_tnp = tnp; p_tkp = tkp;
        bus.TNO  = CW'(tno);  bus.TNC = CW'(tnc); bus.TOBM = CW'(tobm);
        bus.TNI  = CW'(tni);  bus.TKI = CW'(tki);
        bus.TNP  = CW'(tnp);  bus.TKP = CW'(tkp);
    endtask

    task automatic load_shadow();
        bus.run = 1'b1;
        repeat (4) tick();
        bus.run = 1'b0;
        repeat (3) tick();
    endtask

    // Returns just after start edge S (third edge sampling fs1 high)
    task automatic fire_fs1();
        bus.fs1 = 1'b1;
        repeat (3) tick();
    endtask

    task automatic push_model(input int kmin, input int kmax, input int prev_pn);
        for (int k = kmin; k <= kmax; k++) exp_q.push_back(exp_vec(k, prev_pn));
    endtask

    task automatic push_reject(input int prev_pn);
        exp_q.push_back({6'b100000, 8'(prev_pn)});
        for (int k = 1; k <= 5; k++) exp_q.push_back({6'b000000, 8'(prev_pn)});
    endtask

    task automatic run_checks(input string tag, input int n, input bit tick_first);
        logic [W-1:0] e;
        for (int i = 0; i < n; i++) begin
            if (tick_first || i != 0) tick();
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 14'h1, 14'h0);
            end else begin
                e = exp_q.pop_front();
                check(tag, obs(), e);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.fs1 = 1'b0;
        bus.run = 1'b0;
        set_words(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("reset_outputs", obs(), '0);
        check("reset_state", {12'd0, state_dbg}, '0);
        rst_n = 1'b1;
        repeat (2) tick();

        // start with no shadow loaded
        fire_fs1();
        bus.fs1 = 1'b0;
        push_reject(0);
        run_checks("reject_no_shadow", 6, 1'b0);

        // basic sequence
        set_words(3, 2, 10, 1, 4, 5, 9);
        load_shadow();
        fire_fs1();
        bus.fs1 = 1'b0;
        push_model(0, 28, 0);
        run_checks("basic", 29, 1'b0);

        // empty tx window, rx window beyond period end, fs1 held high throughout
        set_words(0, 2, 10, 4, 4, 5, 20);
        load_shadow();
        fire_fs1();
        push_model(0, 26, 1);
        run_checks("windows_hold_fs1", 27, 1'b0);
        bus.fs1 = 1'b0;
        repeat (3) tick();

        // bad parameters
        set_words(3, 2, 0, 1, 4, 5, 9);
        load_shadow();
        fire_fs1();
        bus.fs1 = 1'b0;
        push_reject(1);
        run_checks("reject_tobm0", 6, 1'b0);

        set_words(3, 0, 10, 1, 4, 5, 9);
        load_shadow();
        fire_fs1();
        bus.fs1 = 1'b0;
        push_reject(1);
        run_checks("reject_tnc0", 6, 1'b0);

        // restart during period 0 of a three-period sequence
        set_words(3, 3, 10, 1, 4, 5, 9);
        load_shadow();
        fire_fs1();
        bus.fs1 = 1'b0;
        push_model(0, 6, 1);
        run_checks("restart_first", 7, 1'b0);
        bus.fs1 = 1'b1;
        push_model(7, 9, 1);
        run_checks("restart_overlap", 3, 1'b1);
        bus.fs1 = 1'b0;
        push_model(1, 38, 0);
        run_checks("restart_second", 38, 1'b1);

        // asynchronous reset in the middle of a run
        fire_fs1();
        bus.fs1 = 1'b0;
        push_model(0, 10, 2);
        run_checks("pre_reset", 11, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", obs(), '0);
        check("async_reset_state", {12'd0, state_dbg}, '0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        fire_fs1();
        bus.fs1 = 1'b0;
        push_reject(0);
        run_checks("reject_after_reset", 6, 1'b0);

        check("queue_drained", 14'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
